mod_mv_triple_decoder: RTL

//  Receive-side decoder for the split multi-variable triple stream (a, b, c).
//  The transmit side emits, per data byte d: a = (d > SAT_THRESH) ? 8'hFF : d,
//  b = d + 1, c = d + 2 (all mod 256). This block checks each triple, recovers d,

---
 rtl/mod_mv_triple_decoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mod_mv_triple_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mod_mv_triple_decoder
// Brief    : Checks (a, b, c) triples, recovers the data byte, tracks link lock
//            and counts bad triples; recovered bytes leave on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module mod_mv_triple_decoder #(
    parameter int SAT_THRESH = 100,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [7:0]       in_c,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_sat,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    localparam int               C_GW        = $clog2(LOCK_CNT + 1);
    localparam int               C_BW        = $clog2(UNLOCK_CNT + 1);
    localparam logic [C_GW-1:0]  C_LOCK_LAST = C_GW'(LOCK_CNT - 1);
    localparam logic [C_BW-1:0]  C_DROP_LAST = C_BW'(UNLOCK_CNT - 1);
    localparam logic [7:0]       C_SAT       = SAT_THRESH[7:0];
    localparam logic [CNT_W-1:0] C_ERR_MAX   = '1;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [C_GW-1:0]  r_good_run;
    logic [C_BW-1:0]  r_bad_run;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_sat;
    logic             r_locked;
    logic [CNT_W-1:0] r_err_count;

    logic [7:0] w_d;
    logic [7:0] w_exp_a;
    logic       w_sat;
    logic       w_good;
    logic       w_accept;

    // Triple check: lane b carries d+1, so d and the expected a/c lanes follow from it.
    assign w_d      = in_b - 8'd1;
    assign w_sat    = (w_d > C_SAT);
    assign w_exp_a  = w_sat ? 8'hFF : w_d;
    assign w_good   = (in_a == w_exp_a) && (in_c == in_b + 8'd1);
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_HUNT;
            r_good_run  <= '0;
            r_bad_run   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_sat   <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_good) begin
                            r_bad_run <= '0;
                            if (r_good_run == C_LOCK_LAST) begin
                                r_state     <= ST_LOCKED;
                                r_locked    <= 1'b1;
                                r_good_run  <= '0;
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_d;
                                r_out_sat   <= w_sat;
                            end else begin
                                r_good_run <= r_good_run + 1'b1;
                            end
                        end else begin
                            r_good_run <= '0;
                        end
                    end
                    default: begin
                        if (w_good) begin
                            r_bad_run   <= '0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_d;
                            r_out_sat   <= w_sat;
                        end else if (r_bad_run == C_DROP_LAST) begin
                            r_state    <= ST_HUNT;
                            r_locked   <= 1'b0;
                            r_bad_run  <= '0;
                            r_good_run <= '0;
                        end else begin
                            r_bad_run <= r_bad_run + 1'b1;
                        end
                    end
                endcase
            end

            if (err_clr) begin
                r_err_count <= '0;
            end else if (w_accept && !w_good && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign locked    = r_locked;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
